// File: rtl/round_sequencer.sv
// Round/stage sequencer: launches each datapath stage in turn, waits for its
// completion pulse, and ping-pongs the buffer bank between stages.
module round_sequencer #(
   parameter int NUM_ROUNDS = 24,
   parameter int NUM_STAGES = 5,
   parameter int TIMEOUT    = 1023
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [NUM_STAGES-1:0] stage_done,
   output logic [NUM_STAGES-1:0] stage_start,
   output logic [2:0]            stage_idx,
   output logic [4:0]            round_idx,
   output logic                  bank_sel,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT,
      ADVANCE,
      FINISH
   } state_t;

   localparam logic [2:0]  LAST_STAGE = 3'(NUM_STAGES - 1);
   localparam logic [4:0]  LAST_ROUND = 5'(NUM_ROUNDS - 1);
   localparam logic [15:0] LAST_WAIT  = 16'(TIMEOUT - 1);

   state_t          state, state_n;
   logic [2:0]      stage_n;
   logic [4:0]      round_n;
   logic            bank_n, err_n;
   logic [15:0]     wait_cnt, wait_n;
   logic [NUM_STAGES-1:0] sel_mask;
   logic            hit, stray;

   assign sel_mask = NUM_STAGES'(1) << stage_idx;
   assign hit      = (state == WAIT) && |(stage_done & sel_mask);
   // Any completion bit not belonging to the stage currently awaited is stray.
   assign stray    = (state == WAIT) ? |(stage_done & ~sel_mask)
                                     : (state != IDLE) && |stage_done;

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples the pre-edge values computed by the comb block.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         stage_idx <= '0;
         round_idx <= '0;
         bank_sel  <= 1'b0;
         err       <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         state     <= state_n;
         stage_idx <= stage_n;
         round_idx <= round_n;
         bank_sel  <= bank_n;
         err       <= err_n;
         wait_cnt  <= wait_n;
      end
   end

   // NOTE: every comb output gets a hold default first, so no path can infer a latch.
   always_comb begin
      state_n = state;
      stage_n = stage_idx;
      round_n = round_idx;
      bank_n  = bank_sel;
      err_n   = err | stray;
      wait_n  = wait_cnt;
      unique case (state)
         IDLE: begin
            if (start) begin
               stage_n = '0;
               round_n = '0;
               bank_n  = 1'b0;
               err_n   = 1'b0;
               state_n = LAUNCH;
            end
         end
         LAUNCH: begin
            wait_n  = '0;
            state_n = WAIT;
         end
         WAIT: begin
            if (hit) begin
               state_n = ADVANCE;
            end else if (wait_cnt == LAST_WAIT) begin
               err_n   = 1'b1;
               state_n = FINISH;
            end else begin
               wait_n = wait_cnt + 16'd1;
            end
         end
         ADVANCE: begin
            bank_n = ~bank_sel;
            if (stage_idx < LAST_STAGE) begin
               stage_n = stage_idx + 3'd1;
               state_n = LAUNCH;
            end else if (round_idx < LAST_ROUND) begin
               stage_n = '0;
               round_n = round_idx + 5'd1;
               state_n = LAUNCH;
            end else begin
               state_n = FINISH;
            end
         end
         FINISH:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Moore outputs: decoded purely from registered state and counters.
   assign stage_start = (state == LAUNCH) ? sel_mask : '0;
   assign busy        = (state != IDLE);
   assign done        = (state == FINISH);

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer: two 2-round x 2-stage instances, one with
// a long timeout (index 0) and one with TIMEOUT=4 (index 1).
module tb_round_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start      [2];
   logic [1:0] stage_done [2];
   logic [1:0] stage_start[2];
   logic [2:0] stage_idx  [2];
   logic [4:0] round_idx  [2];
   logic       bank_sel   [2];
   logic       busy       [2];
   logic       done       [2];
   logic       err        [2];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   round_sequencer #(.NUM_ROUNDS(2), .NUM_STAGES(2), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .start(start[0]), .stage_done(stage_done[0]),
      .stage_start(stage_start[0]), .stage_idx(stage_idx[0]), .round_idx(round_idx[0]),
      .bank_sel(bank_sel[0]), .busy(busy[0]), .done(done[0]), .err(err[0]));

   round_sequencer #(.NUM_ROUNDS(2), .NUM_STAGES(2), .TIMEOUT(4)) dut_to (
      .clk(clk), .rst(rst), .start(start[1]), .stage_done(stage_done[1]),
      .stage_start(stage_start[1]), .stage_idx(stage_idx[1]), .round_idx(round_idx[1]),
      .bank_sel(bank_sel[1]), .busy(busy[1]), .done(done[1]), .err(err[1]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check_reset_values(input int d, input string tag);
      check({tag, "_stage_start"}, 32'(stage_start[d]), 0);
      check({tag, "_stage_idx"},   32'(stage_idx[d]),   0);
      check({tag, "_round_idx"},   32'(round_idx[d]),   0);
      check({tag, "_bank_sel"},    32'(bank_sel[d]),    0);
      check({tag, "_busy"},        32'(busy[d]),        0);
      check({tag, "_done"},        32'(done[d]),        0);
      check({tag, "_err"},         32'(err[d]),         0);
   endtask

   // One full 2x2 run. The stage at (slow_r, slow_s) gets its done after slow_w
   // WAIT cycles; others answer in the first WAIT cycle.
   // stray=1: stage_done[1] alone in the first WAIT of stage (0,0), real done next cycle.
   // stray=2: stage_done=11 in the first WAIT of stage (0,0).
   // Ends in the IDLE cycle right after the done pulse.
   task automatic run(input int d, input int slow_r, input int slow_s, input int slow_w,
                      input int stray, input bit mid_start, input bit exp_err,
                      input int exp_lat, input string tag);
      int c0;
      int w;
      logic exp_bank;
      exp_bank = 1'b0;
      start[d] = 1'b1;
      tick();
      start[d] = 1'b0;
      c0 = cyc;
      check({tag, "_err_cleared"}, 32'(err[d]), 0);
      for (int r = 0; r < 2; r++) begin
         for (int s = 0; s < 2; s++) begin
            w = (r == slow_r && s == slow_s) ? slow_w : 1;
            if (stray == 1 && r == 0 && s == 0) w = 2;
            check($sformatf("%s_launch%0d%0d", tag, r, s), 32'(stage_start[d]), 32'(1 << s));
            check($sformatf("%s_stage%0d%0d", tag, r, s),  32'(stage_idx[d]), 32'(s));
            check($sformatf("%s_round%0d%0d", tag, r, s),  32'(round_idx[d]), 32'(r));
            check($sformatf("%s_bank%0d%0d", tag, r, s),   32'(bank_sel[d]), 32'(exp_bank));
            tick();
            check($sformatf("%s_pulse1cyc%0d%0d", tag, r, s), 32'(stage_start[d]), 0);
            for (int i = 1; i <= w; i++) begin
               if (mid_start && r == 0 && s == 1 && i == 1) start[d] = 1'b1;
               if (i == w) stage_done[d] = 2'(1 << s);
               if (stray == 1 && r == 0 && s == 0 && i == 1) stage_done[d] = 2'b10;
               if (stray == 2 && r == 0 && s == 0) stage_done[d] = 2'b11;
               tick();
               start[d]      = 1'b0;
               stage_done[d] = 2'b00;
            end
            tick();
            exp_bank = ~exp_bank;
         end
      end
      check({tag, "_done"},     32'(done[d]), 1);
      check({tag, "_latency"},  32'(cyc - c0 + 1), 32'(exp_lat));
      check({tag, "_err"},      32'(err[d]), 32'(exp_err));
      tick();
      check({tag, "_done_1cyc"}, 32'(done[d]), 0);
      check({tag, "_idle"},      32'(busy[d]), 0);
      check({tag, "_hold_round"}, 32'(round_idx[d]), 1);
      check({tag, "_hold_stage"}, 32'(stage_idx[d]), 1);
      check({tag, "_hold_bank"},  32'(bank_sel[d]), 0);
      check({tag, "_hold_err"},   32'(err[d]), 32'(exp_err));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      for (int d = 0; d < 2; d++) begin
         start[d]      = 1'b0;
         stage_done[d] = 2'b00;
      end

      // Reset with start and stage_done both forced high: reset must win.
      rst = 1'b1;
      start[0] = 1'b1;
      stage_done[0] = 2'b11;
      tick();
      tick();
      start[0] = 1'b0;
      stage_done[0] = 2'b00;
      check_reset_values(0, "reset");
      check_reset_values(1, "reset_to");
      rst = 1'b0;
      tick();
      check("no_start_stays_idle", 32'(busy[0]), 0);

      // Nominal: each stage is 3 cycles, done in cycle 3*2*2+1 = 13 of the run.
      run(0, -1, -1, 1, 0, 1'b0, 1'b0, 13, "nominal");

      // Stage 1 of round 0 answers after 7 WAIT cycles: +6 cycles only.
      run(0, 0, 1, 7, 0, 1'b0, 1'b0, 19, "delayed");

      // Stray bit first then real done (+1 WAIT cycle), and a mid-run start.
      run(0, -1, -1, 1, 1, 1'b1, 1'b1, 14, "stray");
      tick();
      check("mid_start_not_queued", 32'(busy[0]), 0);

      // Expected and stray done together: normal timing, err set.
      run(0, -1, -1, 1, 2, 1'b0, 1'b1, 13, "simul");

      // Back-to-back: start in the IDLE cycle after done, err must clear.
      run(0, -1, -1, 1, 0, 1'b0, 1'b0, 13, "b2b");

      // Timeout, TIMEOUT=4, stage 0 never answers.
      start[1] = 1'b1;
      tick();
      start[1] = 1'b0;
      check("to_launch", 32'(stage_start[1]), 32'h1);
      found = 1'b0;
      for (int k = 1; k <= 6 && !found; k++) begin
         tick();
         if (done[1] === 1'b1) found = 1'b1;
      end
      check("to_done_within_6", 32'(found), 1);
      check("to_err", 32'(err[1]), 1);
      tick();
      check("to_idle", 32'(busy[1]), 0);
      check("to_hold_round", 32'(round_idx[1]), 0);
      check("to_hold_stage", 32'(stage_idx[1]), 0);
      check("to_hold_err", 32'(err[1]), 1);

      // Done arriving in the last permitted WAIT cycle beats the timeout: +3 cycles.
      run(1, 0, 0, 4, 0, 1'b0, 1'b0, 16, "edge_to");

      // Reset during WAIT of round 1, stage 0.
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      for (int s = 0; s < 2; s++) begin
         tick();
         stage_done[0] = 2'(1 << s);
         tick();
         stage_done[0] = 2'b00;
         tick();
      end
      check("rst_mid_round", 32'(round_idx[0]), 1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_values(0, "rst_mid");
      stage_done[0] = 2'b01;
      tick();
      stage_done[0] = 2'b00;
      check("rst_late_done_busy", 32'(busy[0]), 0);
      check("rst_late_done_err",  32'(err[0]), 0);
      check("rst_late_done_done", 32'(done[0]), 0);
      run(0, -1, -1, 1, 0, 1'b0, 1'b0, 13, "after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
